// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, applies redirects, honours stall/flush
// and registers instruction, PC+4 and a valid bit into the IF/ID boundary.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_BOOT | first cycle after reset, IF/ID gets a bubble, PC holds
// S_RUN  | normal fetch with redirect > flush > stall > fetch priority
// S_HALT | HALT_WORD was latched, PC frozen, bubbles until reset
module mips_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          IMEM_AW   = 8,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    input  logic               jump,
    input  logic [31:0]        jump_target,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        if_id_instruction,
    output logic [31:0]        if_id_pc_plus4,
    output logic               if_id_valid,
    output logic [31:0]        pc,
    output logic               halted,
    output logic [15:0]        fetch_count,
    output logic [15:0]        bubble_count
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [31:0] INSN_NOP = 32'h0000_0000;

    state_t      state;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic [31:0] redirect_target;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign pc_plus4  = pc + 32'd4;
    assign redirect  = jump | branch_taken;
    assign imem_addr = pc[IMEM_AW+1:2];
    assign halted    = (state == S_HALT);

    // jump outranks branch; targets are forced word-aligned
    always_comb begin
        redirect_target = jump ? jump_target : branch_target;
        redirect_target = redirect_target & 32'hFFFF_FFFC;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= S_BOOT;
            pc                <= RESET_PC;
            if_id_instruction <= INSN_NOP;
            if_id_pc_plus4    <= 32'h0;
            if_id_valid       <= 1'b0;
            fetch_count       <= 16'h0;
            bubble_count      <= 16'h0;
        end else begin
            case (state)
                S_BOOT: begin
                    if_id_instruction <= INSN_NOP;
                    if_id_valid       <= 1'b0;
                    bubble_count      <= sat_inc(bubble_count);
                    state             <= S_RUN;
                end
                S_RUN: begin
                    if (redirect) begin
                        pc                <= redirect_target;
                        if_id_instruction <= INSN_NOP;
                        if_id_valid       <= 1'b0;
                        bubble_count      <= sat_inc(bubble_count);
                    end else if (flush) begin
                        if (!stall) begin
                            pc <= pc_plus4;
                        end
                        if_id_instruction <= INSN_NOP;
                        if_id_valid       <= 1'b0;
                        bubble_count      <= sat_inc(bubble_count);
                    end else if (!stall) begin
                        pc                <= pc_plus4;
                        if_id_instruction <= imem_rdata;
                        if_id_pc_plus4    <= pc_plus4;
                        if_id_valid       <= 1'b1;
                        fetch_count       <= sat_inc(fetch_count);
                        if (imem_rdata == HALT_WORD) begin
                            state <= S_HALT;
                        end
                    end
                end
                S_HALT: begin
                    if_id_instruction <= INSN_NOP;
                    if_id_valid       <= 1'b0;
                    bubble_count      <= sat_inc(bubble_count);
                end
                default: begin
                    state <= S_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Self-checking bench for mips_fetch_stage: directed scenarios plus randomized
// hazard/redirect traffic compared against a behavioural reference model.
module tb_mips_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, branch_taken = 1'b0, jump = 1'b0;
    logic [31:0] branch_target = 32'h0, jump_target = 32'h0;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instruction, if_id_pc_plus4, pc;
    logic        if_id_valid, halted;
    logic [15:0] fetch_count, bubble_count;

    logic [31:0] mem [256];
    assign imem_rdata = mem[imem_addr];

    mips_fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_id_instruction(if_id_instruction), .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid(if_id_valid), .pc(pc), .halted(halted),
        .fetch_count(fetch_count), .bubble_count(bubble_count)
    );

    // second instance starting at the top of the address space
    logic        reset2 = 1'b0;
    logic        zero1 = 1'b0;
    logic [31:0] zero32 = 32'h0;
    logic [7:0]  imem_addr2;
    logic [31:0] imem_rdata2;
    logic [31:0] ins2, pp4_2, pc2;
    logic        valid2, halted2;
    logic [15:0] fcnt2, bcnt2;
    assign imem_rdata2 = mem[imem_addr2];

    mips_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset2), .stall(zero1), .flush(zero1),
        .branch_taken(zero1), .branch_target(zero32),
        .jump(zero1), .jump_target(zero32),
        .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .if_id_instruction(ins2), .if_id_pc_plus4(pp4_2),
        .if_id_valid(valid2), .pc(pc2), .halted(halted2),
        .fetch_count(fcnt2), .bubble_count(bcnt2)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] m_pc, m_ins, m_pp4;
    logic        m_valid, m_halt, m_boot;
    int          m_fetch, m_bubble;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sat16(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    task automatic model_reset(input logic [31:0] rpc);
        m_pc = rpc; m_ins = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
        m_fetch = 0; m_bubble = 0; m_halt = 1'b0; m_boot = 1'b1;
    endtask

    task automatic model_bubble();
        m_ins = 32'h0; m_valid = 1'b0; m_bubble = sat16(m_bubble);
    endtask

    // advance the model by one clock edge using the inputs currently driven
    task automatic model_edge();
        logic [31:0] w;
        if (m_halt) begin
            model_bubble();
        end else if (m_boot) begin
            model_bubble();
            m_boot = 1'b0;
        end else if (jump || branch_taken) begin
            m_pc = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
            model_bubble();
        end else if (flush) begin
            model_bubble();
            if (!stall) m_pc = m_pc + 32'd4;
        end else if (!stall) begin
            w = mem[m_pc[9:2]];
            m_ins = w; m_pp4 = m_pc + 32'd4; m_valid = 1'b1;
            m_fetch = sat16(m_fetch);
            m_pc = m_pc + 32'd4;
            if (w == 32'hFFFF_FFFF) m_halt = 1'b1;
        end
    endtask

    task automatic compare_all();
        check("pc", pc, m_pc);
        check("imem_addr", {24'h0, imem_addr}, {24'h0, m_pc[9:2]});
        check("instruction", if_id_instruction, m_ins);
        check("valid", {31'h0, if_id_valid}, {31'h0, m_valid});
        if (m_valid) check("pc_plus4", if_id_pc_plus4, m_pp4);
        check("fetch_count", {16'h0, fetch_count}, m_fetch);
        check("bubble_count", {16'h0, bubble_count}, m_bubble);
        check("halted", {31'h0, halted}, {31'h0, m_halt});
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_target = 32'h0; jump_target = 32'h0;
    endtask

    // asserted between edges so the reset is seen asynchronously
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset(32'h0);
        compare_all();
        check("rst_pc_plus4", if_id_pc_plus4, 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    int b0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        #3;
        reset2 = 1'b1;
        async_reset();

        // boot bubble then straight-line fetch
        step();
        check("boot_valid", {31'h0, if_id_valid}, 32'h0);
        step();
        check("f0_ins", if_id_instruction, 32'h1000_0000);
        check("f0_pp4", if_id_pc_plus4, 32'h4);
        step();
        check("f1_ins", if_id_instruction, 32'h1000_0001);
        check("f1_pp4", if_id_pc_plus4, 32'h8);
        step();
        check("f2_fetch_count", {16'h0, fetch_count}, 32'd3);
        check("f2_bubble_count", {16'h0, bubble_count}, 32'd1);
        step();
        check("pre_stall_pc", pc, 32'h10);

        // stall holds everything
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc, 32'h10);
            check("stall_ins", if_id_instruction, 32'h1000_0003);
        end
        stall = 1'b0;
        step();
        check("post_stall_ins", if_id_instruction, 32'h1000_0004);
        check("post_stall_pc", pc, 32'h14);

        // jump beats branch and stall
        branch_taken = 1'b1; jump = 1'b1; stall = 1'b1;
        branch_target = 32'h40; jump_target = 32'h80;
        step();
        check("redir_pc", pc, 32'h80);
        check("redir_valid", {31'h0, if_id_valid}, 32'h0);
        clear_inputs();
        step();
        check("redir_next_ins", if_id_instruction, 32'h1000_0020);
        check("redir_next_valid", {31'h0, if_id_valid}, 32'h1);

        // flush alone at 0x20
        jump = 1'b1; jump_target = 32'h20;
        step();
        clear_inputs();
        flush = 1'b1;
        b0 = bubble_count;
        step();
        check("flush_valid", {31'h0, if_id_valid}, 32'h0);
        check("flush_pc", pc, 32'h24);
        check("flush_bubbles", {16'h0, bubble_count}, b0 + 1);
        clear_inputs();

        // randomized hazards and redirects
        for (int n = 0; n < 400; n++) begin
            stall         = ($urandom_range(0, 99) < 15);
            flush         = ($urandom_range(0, 99) < 8);
            jump          = ($urandom_range(0, 99) < 8);
            branch_taken  = ($urandom_range(0, 99) < 10);
            jump_target   = $urandom();
            branch_target = $urandom();
            step();
        end
        clear_inputs();

        // halt word at word 5
        mem[5] = 32'hFFFF_FFFF;
        async_reset();
        for (int i = 0; i < 7; i++) step();
        check("halt_halted", {31'h0, halted}, 32'h1);
        check("halt_pc", pc, 32'h18);
        jump = 1'b1; jump_target = 32'h100;
        step();
        check("halt_jump_pc", pc, 32'h18);
        check("halt_jump_valid", {31'h0, if_id_valid}, 32'h0);
        clear_inputs();
        step();
        async_reset();
        check("halt_reset_pc", pc, 32'h0);
        check("halt_reset_halted", {31'h0, halted}, 32'h0);
        mem[5] = 32'h1000_0005;

        // PC wrap from 0xFFFF_FFFC
        check("wrap_reset_pc", pc2, 32'hFFFF_FFFC);
        reset2 = 1'b0;
        step();
        check("wrap_boot_valid", {31'h0, valid2}, 32'h0);
        step();
        check("wrap_valid", {31'h0, valid2}, 32'h1);
        check("wrap_ins", ins2, 32'h1000_00FF);
        check("wrap_pp4", pp4_2, 32'h0);
        check("wrap_pc", pc2, 32'h0);
        step();
        check("wrap_next_ins", ins2, 32'h1000_0000);
        check("wrap_next_pc", pc2, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
